// File: rtl/tage_sched_pkg.sv
// Shared types for the TAGE/SC table SRAM access scheduler.
// Holds the scheduler FSM states, the queue-count width helper and the
// default-geometry update entry.
package tage_sched_pkg;

  // Scheduler FSM: sweep the bank to zero, then arbitrate.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Occupancy counter width for a power-of-two queue: it must hold 0..depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Default table geometry (11-bit set index, 16-bit row).
  localparam int DEF_IDX_W  = 11;
  localparam int DEF_DATA_W = 16;

  // One queued update write at the default geometry. Instances built for a
  // different geometry pass their own struct type to the FIFO.
  typedef struct packed {
    logic [DEF_IDX_W-1:0]  idx;
    logic [DEF_DATA_W-1:0] data;
  } upd_entry_t;

endpackage

// File: rtl/tage_upd_fifo.sv
// Update-write queue for the TAGE SRAM scheduler.
// Power-of-two FIFO with same-cycle head visibility; a push into a full queue
// succeeds when a pop happens in the same cycle. All slots and their valid
// bits are exposed so the write-bypass comparators can search the queue.
module tage_upd_fifo
  import tage_sched_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = upd_entry_t
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  entry_t                     push_entry,
  input  logic                       pop,
  output entry_t                     head_entry,
  output entry_t [DEPTH-1:0]         entries,
  output logic   [DEPTH-1:0]         valid,
  output logic   [$clog2(DEPTH)-1:0] head_ptr,
  output logic                       full,
  output logic                       empty,
  output logic                       push_ok
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  entry_t [DEPTH-1:0] mem;
  logic [PTR_W-1:0]   head_reg;
  logic [PTR_W-1:0]   tail_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               do_pop;

  assign full       = (count_reg == CNT_W'(DEPTH));
  assign empty      = (count_reg == '0);
  assign do_pop     = pop && !empty;
  assign push_ok    = push && (!full || do_pop);
  assign head_entry = mem[head_reg];
  assign head_ptr   = head_reg;

  // A slot is live when its distance from the head is below the occupancy.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    assign entries[gi] = mem[gi];
    assign valid[gi]   = ({1'b0, PTR_W'(gi) - head_reg} < count_reg);
  end

  // Storage needs no reset: slot validity comes from the pointers.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[tail_reg] <= push_entry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push_ok) tail_reg <= tail_reg + PTR_W'(1);
      if (do_pop)  head_reg <= head_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(push_ok) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/tage_sram_sched.sv
// Access scheduler for one single-port TAGE/SC table SRAM bank.
// After reset it sweeps the bank to zero, then each cycle arbitrates between a
// prediction read and the head of the update queue. Reads win until a pending
// write has been denied STARVE_MAX times in a row.
// Optional feature: define TAGE_SCHED_WRBYPASS_EN to forward queued update
// data to a granted read that hits the same set index.
module tage_sram_sched
  import tage_sched_pkg::*;
#(
  parameter int IDX_W      = 11,
  parameter int DATA_W     = 16,
  parameter int UPD_QDEPTH = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rd_req_valid,
  input  logic [IDX_W-1:0]  rd_req_idx,
  output logic              rd_grant,
  input  logic              upd_in_valid,
  input  logic [IDX_W-1:0]  upd_in_idx,
  input  logic [DATA_W-1:0] upd_in_data,
  output logic              sram_en,
  output logic              sram_wen,
  output logic [IDX_W-1:0]  sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              init_done,
  output logic              upd_q_full,
  output logic [5:0]        drop_cnt,
  output logic              fwd_valid,
  output logic [DATA_W-1:0] fwd_data
);

  localparam int PTR_W = $clog2(UPD_QDEPTH);
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t                      state_reg, state_next;
  logic [IDX_W-1:0]            ptr_reg;
  logic [STV_W-1:0]            starve_reg, starve_next;
  logic [5:0]                  drop_reg;
  logic                        push_req, pop, push_ok;
  logic                        fifo_full, fifo_empty;
  entry_t                      head_entry;
  entry_t [UPD_QDEPTH-1:0]     fifo_entries;
  logic   [UPD_QDEPTH-1:0]     fifo_valid;
  logic   [PTR_W-1:0]          fifo_head_ptr;

  // Updates arriving during the sweep are discarded: the table is being cleared.
  assign push_req   = upd_in_valid && (state_reg == RUN);
  assign init_done  = (state_reg == RUN);
  assign upd_q_full = fifo_full;
  assign drop_cnt   = drop_reg;

  tage_upd_fifo #(
    .DEPTH   (UPD_QDEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push_req),
    .push_entry ('{idx: upd_in_idx, data: upd_in_data}),
    .pop        (pop),
    .head_entry (head_entry),
    .entries    (fifo_entries),
    .valid      (fifo_valid),
    .head_ptr   (fifo_head_ptr),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .push_ok    (push_ok)
  );

  // Sweep / arbitration: SRAM controls from registered state plus the request.
  always_comb begin
    state_next  = state_reg;
    starve_next = starve_reg;
    sram_en     = 1'b0;
    sram_wen    = 1'b0;
    sram_addr   = '0;
    sram_wdata  = '0;
    rd_grant    = 1'b0;
    pop         = 1'b0;
    if (state_reg == INIT) begin
      sram_en   = 1'b1;
      sram_wen  = 1'b1;
      sram_addr = ptr_reg;
      if (ptr_reg == '1) state_next = RUN;
    end else if (rd_req_valid && (fifo_empty || starve_reg < STV_W'(STARVE_MAX))) begin
      rd_grant    = 1'b1;
      sram_en     = 1'b1;
      sram_addr   = rd_req_idx;
      starve_next = fifo_empty ? '0 : starve_reg + STV_W'(1);
    end else if (!fifo_empty) begin
      sram_en     = 1'b1;
      sram_wen    = 1'b1;
      sram_addr   = head_entry.idx;
      sram_wdata  = head_entry.data;
      pop         = 1'b1;
      starve_next = '0;
    end else begin
      starve_next = '0;
    end
  end

  // FSM, sweep pointer, starvation counter and saturating drop counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= INIT;
      ptr_reg    <= '0;
      starve_reg <= '0;
      drop_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      starve_reg <= starve_next;
      if (state_reg == INIT) ptr_reg <= ptr_reg + IDX_W'(1);
      if (push_req && !push_ok && drop_reg != 6'd63) drop_reg <= drop_reg + 6'd1;
    end
  end

`ifdef TAGE_SCHED_WRBYPASS_EN
  logic [UPD_QDEPTH-1:0] match;
  logic [PTR_W-1:0]      slot;
  logic                  hit;
  logic [DATA_W-1:0]     hit_data;
  logic                  fwd_valid_reg;
  logic [DATA_W-1:0]     fwd_data_reg;

  for (genvar gi = 0; gi < UPD_QDEPTH; gi++) begin : g_cmp
    assign match[gi] = fifo_valid[gi] && (fifo_entries[gi].idx == rd_req_idx);
  end

  // Walk oldest to youngest so the youngest hit wins; an update accepted
  // this cycle is younger than anything already queued.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    slot     = '0;
    for (int k = 0; k < UPD_QDEPTH; k++) begin
      slot = fifo_head_ptr + PTR_W'(k);
      if (match[slot]) begin
        hit      = 1'b1;
        hit_data = fifo_entries[slot].data;
      end
    end
    if (push_ok && upd_in_idx == rd_req_idx) begin
      hit      = 1'b1;
      hit_data = upd_in_data;
    end
  end

  // Forward result lines up with the SRAM read data one cycle later.
  always_ff @(posedge clock) begin
    if (reset) begin
      fwd_valid_reg <= 1'b0;
      fwd_data_reg  <= '0;
    end else begin
      fwd_valid_reg <= rd_grant && hit;
      fwd_data_reg  <= hit_data;
    end
  end

  assign fwd_valid = fwd_valid_reg;
  assign fwd_data  = fwd_data_reg;
`else
  logic unused_bypass;
  assign unused_bypass = ^{fifo_entries, fifo_valid, fifo_head_ptr};
  assign fwd_valid     = 1'b0;
  assign fwd_data      = '0;
`endif

endmodule
